timer_tick_gen: RTL and testbench

Count-enable generator for the timer: produces the single-cycle `cnt_en` strobe that drives the 64-bit `counter` stage directly downstream. It applies the programmable power-of-two prescaler (`div_en`/`div_val`), the global `timer_en` gate and the debug-halt handshake (`halt_req`/`halt_ack`). Control inputs come from the register block. `cnt_en` connects straight to `counter.cnt_en`.

---
 rtl/timer_pkg.sv | 13 +
 rtl/timer_tick_gen.sv | 121 ++++++++++++
 tb/tb_timer_tick_gen.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared timer definitions: tick generator state encoding and prescaler sizing.
package timer_pkg;

  localparam int unsigned TIMER_DIV_W   = 4;
  localparam int unsigned TIMER_DIV_MAX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } tick_state_t;

endpackage

// File: rtl/timer_tick_gen.sv
// Count-enable strobe generator: power-of-two prescaler, global enable gate and
// debug-halt freeze feeding the 64-bit counter stage.
module timer_tick_gen
  import timer_pkg::*;
#(
  parameter int unsigned DIV_W   = TIMER_DIV_W,
  parameter int unsigned DIV_MAX = TIMER_DIV_MAX
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             dbg_mode,
  input  logic             halt_req,
  output logic             cnt_en,
  output logic             halt_ack
);

  localparam logic [DIV_MAX-1:0] PRE_ONES = '1;

  tick_state_t        r_state;
  tick_state_t        w_state_nxt;
  logic [DIV_MAX-1:0] r_pre_cnt;
  logic [DIV_MAX-1:0] w_pre_cnt_nxt;
  logic [DIV_MAX-1:0] w_limit;
  logic               r_cnt_en;
  logic               w_cnt_en_nxt;
  logic               r_halt_ack;
  logic               r_div_en;
  logic [DIV_W-1:0]   r_div_val;
  logic [DIV_W-1:0]   w_eff;
  logic               w_halt;
  logic               w_ratio_chg;

  assign w_halt      = halt_req & dbg_mode;
  assign w_ratio_chg = (div_en != r_div_en) || (div_val != r_div_val);

  // Effective exponent from the registered ratio, clamped to the prescaler width.
  always_comb begin
    w_eff = '0;
    if (r_div_en) begin
      if (32'(r_div_val) > DIV_MAX) begin
        w_eff = DIV_W'(DIV_MAX);
      end else begin
        w_eff = r_div_val;
      end
    end
  end

  // 2^eff - 1 as a low-ones mask.
  assign w_limit = ~(PRE_ONES << w_eff);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pre_cnt_nxt = r_pre_cnt;
    w_cnt_en_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_pre_cnt_nxt = '0;
        w_state_nxt   = w_halt ? HALT : RUN;
      end
      RUN: begin
        if (r_pre_cnt == w_limit) begin
          w_cnt_en_nxt  = 1'b1;
          w_pre_cnt_nxt = '0;
        end else begin
          w_pre_cnt_nxt = r_pre_cnt + DIV_MAX'(1);
        end
        if (w_halt) begin
          w_state_nxt = HALT;
        end
      end
      HALT: begin
        if (!w_halt) begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_pre_cnt_nxt = '0;
      end
    endcase
    // A ratio change restarts the period but leaves the state machine alone.
    if (w_ratio_chg) begin
      w_pre_cnt_nxt = '0;
      w_cnt_en_nxt  = 1'b0;
    end
    if (!timer_en) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_pre_cnt  <= '0;
      r_cnt_en   <= 1'b0;
      r_halt_ack <= 1'b0;
      r_div_en   <= 1'b0;
      r_div_val  <= '0;
    end else begin
      r_pre_cnt  <= w_pre_cnt_nxt;
      r_cnt_en   <= w_cnt_en_nxt;
      r_halt_ack <= w_halt;
      r_div_en   <= div_en;
      r_div_val  <= div_val;
    end
  end

  assign cnt_en   = r_cnt_en;
  assign halt_ack = r_halt_ack;

endmodule

// File: tb/tb_timer_tick_gen.sv
// Scoreboard bench for timer_tick_gen: stimulus queues per-edge expected
// {cnt_en, halt_ack}; a negedge monitor pops, compares and tallies pulses.
module tb_timer_tick_gen;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       timer_en;
  logic       div_en;
  logic [3:0] div_val;
  logic       dbg_mode;
  logic       halt_req;
  logic       cnt_en;
  logic       halt_ack;

  typedef struct {
    logic [1:0] exp;
    bit         clr;
    bit         chk;
    int         want;
    string      tag;
  } vec_t;

  vec_t sb_q[$];
  vec_t mv;
  int   n_vec;
  int   n_err;
  int   pcnt;

  timer_tick_gen #(.DIV_W(4), .DIV_MAX(8)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .timer_en (timer_en),
    .div_en   (div_en),
    .div_val  (div_val),
    .dbg_mode (dbg_mode),
    .halt_req (halt_req),
    .cnt_en   (cnt_en),
    .halt_ack (halt_ack)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Monitor: one scoreboard entry per clock edge.
  always @(negedge sys_clk) begin
    if (sb_q.size() != 0) begin
      mv = sb_q.pop_front();
      if (mv.clr) pcnt = 0;
      if (cnt_en === 1'b1) pcnt = pcnt + 1;
      n_vec = n_vec + 1;
      if ({cnt_en, halt_ack} !== mv.exp) begin
        n_err = n_err + 1;
        $display("FAIL %s: cnt_en,halt_ack got %b%b want %b at %0t",
                 mv.tag, cnt_en, halt_ack, mv.exp, $time);
      end
      if (mv.chk) begin
        n_vec = n_vec + 1;
        if (pcnt != mv.want) begin
          n_err = n_err + 1;
          $display("FAIL %s_pulses: got %0d want %0d", mv.tag, pcnt, mv.want);
        end
      end
    end
  end

  task automatic cyc(input logic c, input logic a, input string tag,
                     input bit clr, input bit chk, input int want);
    vec_t v;
    v.exp  = {c, a};
    v.clr  = clr;
    v.chk  = chk;
    v.want = want;
    v.tag  = tag;
    sb_q.push_back(v);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic cy(input logic c, input logic a, input string tag);
    cyc(c, a, tag, 1'b0, 1'b0, 0);
  endtask

  // Enable for n_on edges (RUN entered at edge 1, pulses at 1+k*per),
  // then one disabling edge still in RUN, then one idle edge with pulse check.
  task automatic run_phase(input int n_on, input int per, input logic ack,
                           input string tag, input int want);
    logic e;
    timer_en = 1'b1;
    for (int i = 1; i <= n_on + 1; i++) begin
      if (i == n_on + 1) timer_en = 1'b0;
      e = (i > 1) && (((i - 1) % per) == 0);
      cyc(e, ack, tag, i == 1, 1'b0, 0);
    end
    cyc(1'b0, ack, tag, 1'b0, 1'b1, want);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    pcnt      = 0;
    sys_rst_n = 1'b0;
    timer_en  = 1'b0;
    div_en    = 1'b0;
    div_val   = 4'd0;
    dbg_mode  = 1'b0;
    halt_req  = 1'b0;

    repeat (3) cy(1'b0, 1'b0, "reset");
    sys_rst_n = 1'b1;
    cy(1'b0, 1'b0, "idle");

    // Undivided: 10 consecutive strobes
    run_phase(10, 1, 1'b0, "div_off", 10);

    // Divide by 4 over 40 enabled cycles
    div_en  = 1'b1;
    div_val = 4'd2;
    cy(1'b0, 1'b0, "set_div2");
    run_phase(40, 4, 1'b0, "div4", 10);

    // Exponent 15 clamps to 256
    div_val = 4'd15;
    cy(1'b0, 1'b0, "set_div15");
    run_phase(1024, 256, 1'b0, "clamp", 4);

    // Debug halt mid-period preserves remaining count
    div_val  = 4'd3;
    dbg_mode = 1'b1;
    cy(1'b0, 1'b0, "set_div8");
    timer_en = 1'b1;
    for (int i = 1; i <= 42; i++) begin
      if (i >= 6 && i <= 25) halt_req = 1'b1;
      else halt_req = 1'b0;
      if (i == 41) timer_en = 1'b0;
      cyc((i == 29) || (i == 37), (i >= 6) && (i <= 25), "halt",
          i == 1, i == 42, 2);
    end

    // Halt request ignored outside debug mode
    dbg_mode = 1'b0;
    halt_req = 1'b1;
    run_phase(17, 8, 1'b0, "nodbg", 2);
    halt_req = 1'b0;

    // Ratio change at pre_cnt == 5, then off together with another change
    timer_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if (i == 7) div_val = 4'd1;
      if (i == 15) begin
        timer_en = 1'b0;
        div_val  = 4'd2;
      end
      cyc((i >= 8) && (i <= 14) && ((i % 2) == 1), 1'b0, "ratio_chg",
          i == 1, i == 16, 3);
    end

    // Reset on the edge where a strobe and a halt would land
    div_val = 4'd3;
    cy(1'b0, 1'b0, "set_div8b");
    timer_en = 1'b1;
    for (int i = 1; i <= 8; i++) cy(1'b0, 1'b0, "pre_rst");
    sys_rst_n = 1'b0;
    dbg_mode  = 1'b1;
    halt_req  = 1'b1;
    cy(1'b0, 1'b0, "rst_drop");
    sys_rst_n = 1'b1;
    dbg_mode  = 1'b0;
    halt_req  = 1'b0;
    div_en    = 1'b0;
    run_phase(3, 1, 1'b0, "post_rst", 3);

    @(negedge sys_clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
